// File: rtl/fpdiv_sched.sv
// Two-requester scheduler in front of a single multi-cycle FP divider.
// Round-robin grant, one operation in flight, timeout abort to a quiet NaN.
//
// state | meaning
// IDLE  | waiting for a request; combinational grant
// ISSUE | start pulse to divider with latched operands
// WAIT  | waiting for div_done_i or timeout
// RESP  | response held to the owner until accepted
module fpdiv_sched #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [63:0] req_a_i,
    input  logic [63:0] req_b_i,
    output logic        div_start_o,
    output logic [31:0] div_a_o,
    output logic [31:0] div_b_o,
    input  logic        div_done_i,
    input  logic [31:0] div_z_i,
    output logic [1:0]  rsp_valid_o,
    input  logic [1:0]  rsp_ready_i,
    output logic [31:0] rsp_z_o,
    output logic [7:0]  timeout_cnt_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] QNAN    = 32'hFFC0_0000;

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt;
    logic        owner;
    logic        last_grant;
    logic [31:0] a_q, b_q, result;
    logic [7:0]  timeout_cnt;
    logic [1:0]  grant;
    logic        grant_id;

    // Tie goes to the requester not granted last; a lone requester always wins.
    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        if (req_valid_i == 2'b11) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req_valid_i[1];
        end
        if (state == IDLE && !rst_i && (|req_valid_i)) begin
            grant = grant_id ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (|grant) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (div_done_i || wait_cnt == TO_LAST) state_nxt = RESP;
            RESP:  if (rsp_ready_i[owner]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            result      <= 32'd0;
            timeout_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        a_q        <= grant_id ? req_a_i[63:32] : req_a_i[31:0];
                        b_q        <= grant_id ? req_b_i[63:32] : req_b_i[31:0];
                        owner      <= grant_id;
                        last_grant <= grant_id;
                    end
                end
                ISSUE: wait_cnt <= 8'd0;
                WAIT: begin
                    // done wins over a timeout landing on the same cycle
                    if (div_done_i) begin
                        result <= div_z_i;
                    end else if (wait_cnt == TO_LAST) begin
                        result <= QNAN;
                        if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o   = grant;
    assign div_start_o   = (state == ISSUE);
    assign div_a_o       = a_q;
    assign div_b_o       = b_q;
    assign rsp_valid_o   = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_z_o       = (state == RESP) ? result : 32'd0;
    assign timeout_cnt_o = timeout_cnt;

endmodule

// File: tb/tb_fpdiv_sched.sv
// Self-checking bench for fpdiv_sched: behavioural divider, grant/response
// scoreboard, and one task per scenario.
module tb_fpdiv_sched;
    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [63:0] req_a_i;
    logic [63:0] req_b_i;
    logic        div_start_o;
    logic [31:0] div_a_o, div_b_o;
    logic        div_done_i;
    logic [31:0] div_z_i;
    logic [1:0]  rsp_valid_o;
    logic [1:0]  rsp_ready_i;
    logic [31:0] rsp_z_o;
    logic [7:0]  timeout_cnt_o;

    fpdiv_sched #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i),
        .div_start_o(div_start_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
        .div_done_i(div_done_i), .div_z_i(div_z_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_z_o(rsp_z_o), .timeout_cnt_o(timeout_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        owner;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
    } exp_t;

    exp_t sb[$];
    logic grant_log[$];
    int   rsp_count = 0;
    int   start_count = 0;

    // behavioural divider: done pulses div_lat cycles after the start cycle; 0 = never
    int          div_lat = 0;
    logic [31:0] div_result = 32'd0;
    logic        model_done = 1'b0;
    logic        manual_done = 1'b0;
    int          mcnt = 0;

    assign div_done_i = model_done | manual_done;
    assign div_z_i    = div_result;

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            model_done = 1'b0;
            if (rst_i) begin
                mcnt = 0;
            end else if (div_start_o) begin
                mcnt = div_lat;
            end else if (mcnt != 0) begin
                mcnt--;
                if (mcnt == 0) model_done = 1'b1;
            end
        end
    end

    // scoreboard: push at grant, check operands at issue, pop at response handshake
    exp_t       mon_e;
    logic [1:0] mon_v;
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (|(req_ready_o & req_valid_i)) begin
                    mon_e.owner = req_ready_o[1];
                    mon_e.a = mon_e.owner ? req_a_i[63:32] : req_a_i[31:0];
                    mon_e.b = mon_e.owner ? req_b_i[63:32] : req_b_i[31:0];
                    mon_e.z = (div_lat >= 1 && div_lat <= TO) ? div_result : 32'hFFC0_0000;
                    sb.push_back(mon_e);
                    grant_log.push_back(mon_e.owner);
                end
                if (div_start_o) begin
                    start_count++;
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL issue_operands: start with no granted op");
                    end else if (div_a_o !== sb[0].a || div_b_o !== sb[0].b) begin
                        failures++;
                        $display("FAIL issue_operands: a=%h b=%h want a=%h b=%h",
                                 div_a_o, div_b_o, sb[0].a, sb[0].b);
                    end
                end
                if (|(rsp_valid_o & rsp_ready_i)) begin
                    rsp_count++;
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL response: unexpected rsp_valid=%b z=%h", rsp_valid_o, rsp_z_o);
                    end else begin
                        mon_e = sb.pop_front();
                        mon_v = mon_e.owner ? 2'b10 : 2'b01;
                        if (rsp_valid_o !== mon_v || rsp_z_o !== mon_e.z) begin
                            failures++;
                            $display("FAIL response: valid=%b z=%h want valid=%b z=%h",
                                     rsp_valid_o, rsp_z_o, mon_v, mon_e.z);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_rsp(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_i);
            #1;
            if (rsp_count >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // raises one request, drops it after grant, returns cycles from grant to first rsp_valid inclusive
    task automatic issue_one(input logic id, input logic [31:0] a, input logic [31:0] b,
                             output int lat, output bit ok);
        ok = 1'b0;
        lat = 0;
        @(posedge clk_i);
        #1;
        if (id) begin
            req_a_i[63:32] = a; req_b_i[63:32] = b; req_valid_i = 2'b10;
        end else begin
            req_a_i[31:0] = a; req_b_i[31:0] = b; req_valid_i = 2'b01;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (req_ready_o[id]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        @(posedge clk_i);
        #1;
        req_valid_i = 2'b00;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            lat++;
            if (rsp_valid_o != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        lat = lat + 1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        req_valid_i = 2'b11;
        rsp_ready_i = 2'b00;
        req_a_i = 64'h1234_5678_9ABC_DEF0;
        req_b_i = 64'h0FED_CBA9_8765_4321;
        repeat (2) @(negedge clk_i);
        checks++; if (req_ready_o !== 2'b00) begin failures++; $display("FAIL reset_req_ready: got %b want 00", req_ready_o); end
        checks++; if (div_start_o !== 1'b0) begin failures++; $display("FAIL reset_div_start: got %b want 0", div_start_o); end
        checks++; if (div_a_o !== 32'd0 || div_b_o !== 32'd0) begin failures++; $display("FAIL reset_div_ops: got %h %h want 0 0", div_a_o, div_b_o); end
        checks++; if (rsp_valid_o !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid_o); end
        checks++; if (rsp_z_o !== 32'd0) begin failures++; $display("FAIL reset_rsp_z: got %h want 0", rsp_z_o); end
        checks++; if (timeout_cnt_o !== 8'd0) begin failures++; $display("FAIL reset_timeout_cnt: got %0d want 0", timeout_cnt_o); end
        @(posedge clk_i);
        #1;
        req_valid_i = 2'b00;
        rst_i = 1'b0;
    endtask

    task automatic test_round_robin();
        bit ok;
        int target;
        div_lat = 1;
        div_result = 32'h3F80_0000;
        rsp_ready_i = 2'b11;
        grant_log.delete();
        target = rsp_count + 4;
        @(posedge clk_i);
        #1;
        req_a_i = {32'h4100_0000, 32'h4080_0000};
        req_b_i = {32'h4100_0000, 32'h4080_0000};
        req_valid_i = 2'b11;
        wait_rsp(target, 100, ok);
        req_valid_i = 2'b00;
        checks++; if (!ok) begin failures++; $display("FAIL rr_progress: got %0d responses want %0d", rsp_count, target); end
        checks++;
        if (grant_log.size() != 4) begin
            failures++; $display("FAIL rr_count: got %0d grants want 4", grant_log.size());
        end else if (grant_log[0] !== 1'b0 || grant_log[1] !== 1'b1 || grant_log[2] !== 1'b0 || grant_log[3] !== 1'b1) begin
            failures++;
            $display("FAIL rr_order: got %b%b%b%b want 0101", grant_log[0], grant_log[1], grant_log[2], grant_log[3]);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int lat, s0, target;
        div_lat = 3;
        div_result = 32'h4040_0000;
        rsp_ready_i = 2'b11;
        s0 = start_count;
        target = rsp_count + 1;
        issue_one(1'b0, 32'h40C0_0000, 32'h4000_0000, lat, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_progress: no grant or response"); end
        checks++; if (lat != 6) begin failures++; $display("FAIL basic_latency: got %0d want 6", lat); end
        checks++; if (rsp_valid_o !== 2'b01 || rsp_z_o !== 32'h4040_0000) begin
            failures++; $display("FAIL basic_rsp: got %b %h want 01 40400000", rsp_valid_o, rsp_z_o);
        end
        wait_rsp(target, 20, ok);
        repeat (3) @(negedge clk_i);
        checks++; if (start_count - s0 != 1) begin failures++; $display("FAIL basic_start_pulses: got %0d want 1", start_count - s0); end
        checks++; if (div_a_o !== 32'h40C0_0000 || div_b_o !== 32'h4000_0000) begin
            failures++; $display("FAIL basic_ops_held: got %h %h want 40c00000 40000000", div_a_o, div_b_o);
        end
        checks++; if (rsp_z_o !== 32'd0) begin failures++; $display("FAIL basic_z_idle: got %h want 0", rsp_z_o); end
    endtask

    task automatic test_min_latency();
        bit ok;
        int lat, target;
        div_lat = 1;
        div_result = 32'h4120_0000;
        rsp_ready_i = 2'b11;
        target = rsp_count + 1;
        issue_one(1'b1, 32'h42C8_0000, 32'h4120_0000, lat, ok);
        checks++; if (!ok || lat != 4) begin failures++; $display("FAIL min_latency: got %0d (ok=%0d) want 4", lat, ok); end
        wait_rsp(target, 20, ok);
    endtask

    task automatic test_timeout();
        bit ok;
        int lat, target;
        logic [7:0] t0;
        div_lat = 0;
        rsp_ready_i = 2'b11;
        t0 = timeout_cnt_o;
        target = rsp_count + 1;
        issue_one(1'b0, 32'h3F80_0000, 32'h0000_0000, lat, ok);
        checks++; if (!ok || lat != TO + 3) begin failures++; $display("FAIL timeout_latency: got %0d want %0d", lat, TO + 3); end
        checks++; if (rsp_z_o !== 32'hFFC0_0000) begin failures++; $display("FAIL timeout_z: got %h want ffc00000", rsp_z_o); end
        checks++; if (timeout_cnt_o !== t0 + 8'd1) begin failures++; $display("FAIL timeout_cnt: got %0d want %0d", timeout_cnt_o, t0 + 8'd1); end
        wait_rsp(target, 20, ok);
    endtask

    task automatic test_coincide();
        bit ok;
        int lat, target;
        logic [7:0] t0;
        div_lat = TO;
        div_result = 32'h4049_0FDB;
        rsp_ready_i = 2'b11;
        t0 = timeout_cnt_o;
        target = rsp_count + 1;
        issue_one(1'b1, 32'h40C9_0FDB, 32'h4000_0000, lat, ok);
        checks++; if (!ok || lat != TO + 3) begin failures++; $display("FAIL coincide_latency: got %0d want %0d", lat, TO + 3); end
        checks++; if (rsp_z_o !== 32'h4049_0FDB) begin failures++; $display("FAIL coincide_z: got %h want 40490fdb", rsp_z_o); end
        checks++; if (timeout_cnt_o !== t0) begin failures++; $display("FAIL coincide_cnt: got %0d want %0d", timeout_cnt_o, t0); end
        wait_rsp(target, 20, ok);
    endtask

    task automatic test_hold();
        bit ok;
        int lat, bad, target;
        div_lat = 2;
        div_result = 32'h4080_0000;
        rsp_ready_i = 2'b00;
        target = rsp_count + 1;
        issue_one(1'b0, 32'h4100_0000, 32'h4000_0000, lat, ok);
        checks++; if (!ok) begin failures++; $display("FAIL hold_progress: no response"); end
        @(posedge clk_i);
        #1;
        rsp_ready_i = 2'b10;
        req_valid_i = 2'b11;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checks++;
            if (rsp_valid_o !== 2'b01 || rsp_z_o !== 32'h4080_0000 || req_ready_o !== 2'b00) begin
                failures++;
                $display("FAIL hold_cycle%0d: valid=%b z=%h grant=%b want 01 40800000 00",
                         i, rsp_valid_o, rsp_z_o, req_ready_o);
            end
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b01;
        wait_rsp(target, 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL hold_release: response not accepted"); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int bad;
        div_lat = 0;
        rsp_ready_i = 2'b11;
        @(posedge clk_i);
        #1;
        req_a_i[31:0] = 32'h4000_0000;
        req_b_i[31:0] = 32'h3F80_0000;
        req_valid_i = 2'b01;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (req_ready_o[0]) begin ok = 1'b1; break; end
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 2'b00;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++; if (!ok) begin failures++; $display("FAIL rstmid_grant: no grant"); end
        checks++; if (div_a_o !== 32'd0 || rsp_valid_o !== 2'b00 || timeout_cnt_o !== 8'd0) begin
            failures++; $display("FAIL rstmid_during: a=%h valid=%b tcnt=%0d want 0 00 0", div_a_o, rsp_valid_o, timeout_cnt_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        sb.delete();
        div_result = 32'h4000_0000;
        manual_done = 1'b1;
        @(posedge clk_i);
        #1;
        manual_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o !== 2'b00 || div_start_o !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rstmid_no_rsp: got %0d active cycles want 0", bad); end
        checks++; if (div_a_o !== 32'd0 || div_b_o !== 32'd0 || rsp_z_o !== 32'd0 || timeout_cnt_o !== 8'd0) begin
            failures++; $display("FAIL rstmid_after: a=%h b=%h z=%h tcnt=%0d want all 0", div_a_o, div_b_o, rsp_z_o, timeout_cnt_o);
        end
    endtask

    task automatic test_saturate();
        bit ok;
        int lat, target, errs;
        div_lat = 0;
        rsp_ready_i = 2'b11;
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            target = rsp_count + 1;
            issue_one(i[0], 32'h3F80_0000, 32'h0000_0000, lat, ok);
            if (!ok) errs++;
            wait_rsp(target, 20, ok);
            if (!ok) errs++;
            if (errs != 0) break;
        end
        checks++; if (errs != 0) begin failures++; $display("FAIL saturate_progress: got %0d stalls want 0", errs); end
        checks++; if (timeout_cnt_o !== 8'd255) begin failures++; $display("FAIL saturate_cnt: got %0d want 255", timeout_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_basic();
        test_min_latency();
        test_timeout();
        test_coincide();
        test_hold();
        test_reset_mid();
        test_saturate();
        repeat (2) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
